// File: rtl/sim_run_ctrl.sv
// Run sequencer between the simulation top and SimTop: reset release, host init,
// step handshakes with the host, and end-of-sim dump/finish. Step limit: SIM_RUN_CTRL_STEP_LIMIT_EN.
//
// state | meaning
// HOLD  | dut_reset high, counting RESET_CYCLES clocks
// INIT  | one-cycle host init request
// RUN   | idle; issue a step from difftest_step or the pending count
// WAIT  | step_req outstanding, waiting for the host response
// DUMP  | perf_dump window of DUMP_CYCLES clocks
// DONE  | finish and trap_code held until reset
module sim_run_ctrl #(
    parameter int RESET_CYCLES = 50,
    parameter int DUMP_CYCLES  = 25,
    parameter int PEND_W       = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] cfg_max_cycles,
`ifdef SIM_RUN_CTRL_STEP_LIMIT_EN
    input  logic [63:0] cfg_max_steps,
    output logic [63:0] steps,
`endif
    input  logic        difftest_step,
    output logic        dut_reset,
    output logic        init_req,
    output logic        step_req,
    input  logic        step_rsp_valid,
    input  logic [7:0]  step_rsp_trap,
    output logic        perf_dump,
    output logic        finish,
    output logic [7:0]  trap_code,
    output logic [63:0] cycles,
    output logic        pend_ovf
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_INIT,
        S_RUN,
        S_WAIT,
        S_DUMP,
        S_DONE
    } state_t;

    localparam int HOLD_W = $clog2(RESET_CYCLES + 1);
    localparam int DUMP_W = $clog2(DUMP_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [DUMP_W-1:0] DUMP_LOAD = DUMP_W'(DUMP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [7:0]        TRAP_TIMEOUT = 8'hFE;
    localparam logic [7:0]        TRAP_STEPLIM = 8'h09;

    state_t             r_state, w_state_nxt;
    logic [HOLD_W-1:0]  r_hold_cnt, w_hold_cnt_nxt;
    logic [DUMP_W-1:0]  r_dump_cnt, w_dump_cnt_nxt;
    logic [PEND_W-1:0]  r_pend, w_pend_nxt;
    logic               r_pend_ovf, w_pend_ovf_nxt;
    logic               r_step_req, w_step_req_nxt;
    logic               r_perf_dump, w_perf_dump_nxt;
    logic               r_finish, w_finish_nxt;
    logic [7:0]         r_trap_code, w_trap_code_nxt;
    logic               r_dut_reset, w_dut_reset_nxt;
    logic               r_init_req, w_init_req_nxt;
    logic [63:0]        r_cycles;
    logic               w_cyc_en;
    logic               w_timeout;
`ifdef SIM_RUN_CTRL_STEP_LIMIT_EN
    logic [63:0]        r_steps, w_steps_nxt;
`endif

    assign w_timeout = (cfg_max_cycles != 64'd0) && (r_cycles == cfg_max_cycles);
    assign w_cyc_en  = (r_state == S_INIT) || (r_state == S_RUN) || (r_state == S_WAIT);

    always_comb begin
        w_state_nxt     = r_state;
        w_hold_cnt_nxt  = r_hold_cnt;
        w_dump_cnt_nxt  = r_dump_cnt;
        w_pend_nxt      = r_pend;
        w_pend_ovf_nxt  = r_pend_ovf;
        w_step_req_nxt  = r_step_req;
        w_perf_dump_nxt = r_perf_dump;
        w_finish_nxt    = r_finish;
        w_trap_code_nxt = r_trap_code;
        w_dut_reset_nxt = r_dut_reset;
        w_init_req_nxt  = 1'b0;
`ifdef SIM_RUN_CTRL_STEP_LIMIT_EN
        w_steps_nxt     = r_steps;
`endif

        case (r_state)
            S_HOLD: begin
                if (r_hold_cnt == HOLD_LAST) begin
                    w_dut_reset_nxt = 1'b0;
                    w_init_req_nxt  = 1'b1;
                    w_state_nxt     = S_INIT;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 1'b1;
                end
            end

            S_INIT: begin
                w_state_nxt = S_RUN;
                if (difftest_step) begin
                    if (r_pend == PEND_MAX) w_pend_ovf_nxt = 1'b1;
                    else                    w_pend_nxt     = r_pend + 1'b1;
                end
            end

            S_RUN: begin
                if (w_timeout) begin
                    w_trap_code_nxt = TRAP_TIMEOUT;
                    w_perf_dump_nxt = 1'b1;
                    w_dump_cnt_nxt  = DUMP_LOAD;
                    w_state_nxt     = S_DUMP;
`ifdef SIM_RUN_CTRL_STEP_LIMIT_EN
                end else if ((cfg_max_steps != 64'd0) && (r_steps >= cfg_max_steps)) begin
                    w_trap_code_nxt = TRAP_STEPLIM;
                    w_perf_dump_nxt = 1'b1;
                    w_dump_cnt_nxt  = DUMP_LOAD;
                    w_state_nxt     = S_DUMP;
`endif
                end else if (difftest_step || (r_pend != '0)) begin
                    // a new step alongside pending ones leaves the count unchanged
                    w_step_req_nxt = 1'b1;
                    w_state_nxt    = S_WAIT;
                    if (!difftest_step) w_pend_nxt = r_pend - 1'b1;
                end
            end

            S_WAIT: begin
                if (difftest_step) begin
                    if (r_pend == PEND_MAX) w_pend_ovf_nxt = 1'b1;
                    else                    w_pend_nxt     = r_pend + 1'b1;
                end
                if (w_timeout) begin
                    w_step_req_nxt  = 1'b0;
                    w_trap_code_nxt = TRAP_TIMEOUT;
                    w_perf_dump_nxt = 1'b1;
                    w_dump_cnt_nxt  = DUMP_LOAD;
                    w_state_nxt     = S_DUMP;
                end else if (step_rsp_valid) begin
                    w_step_req_nxt = 1'b0;
                    if (step_rsp_trap != 8'h00) begin
                        w_trap_code_nxt = step_rsp_trap;
                        w_perf_dump_nxt = 1'b1;
                        w_dump_cnt_nxt  = DUMP_LOAD;
                        w_state_nxt     = S_DUMP;
                    end else begin
`ifdef SIM_RUN_CTRL_STEP_LIMIT_EN
                        w_steps_nxt = r_steps + 64'd1;
                        if ((cfg_max_steps != 64'd0) && ((r_steps + 64'd1) >= cfg_max_steps)) begin
                            w_trap_code_nxt = TRAP_STEPLIM;
                            w_perf_dump_nxt = 1'b1;
                            w_dump_cnt_nxt  = DUMP_LOAD;
                            w_state_nxt     = S_DUMP;
                        end else begin
                            w_state_nxt = S_RUN;
                        end
`else
                        w_state_nxt = S_RUN;
`endif
                    end
                end
            end

            S_DUMP: begin
                if (r_dump_cnt == '0) begin
                    w_perf_dump_nxt = 1'b0;
                    w_finish_nxt    = 1'b1;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_dump_cnt_nxt = r_dump_cnt - 1'b1;
                end
            end

            S_DONE: begin
                w_state_nxt = S_DONE;
            end

            default: begin
                w_state_nxt = S_HOLD;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_HOLD;
            r_hold_cnt  <= '0;
            r_dump_cnt  <= '0;
            r_pend      <= '0;
            r_pend_ovf  <= 1'b0;
            r_step_req  <= 1'b0;
            r_perf_dump <= 1'b0;
            r_finish    <= 1'b0;
            r_trap_code <= 8'h00;
            r_dut_reset <= 1'b1;
            r_init_req  <= 1'b0;
            r_cycles    <= 64'd0;
`ifdef SIM_RUN_CTRL_STEP_LIMIT_EN
            r_steps     <= 64'd0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_cnt_nxt;
            r_dump_cnt  <= w_dump_cnt_nxt;
            r_pend      <= w_pend_nxt;
            r_pend_ovf  <= w_pend_ovf_nxt;
            r_step_req  <= w_step_req_nxt;
            r_perf_dump <= w_perf_dump_nxt;
            r_finish    <= w_finish_nxt;
            r_trap_code <= w_trap_code_nxt;
            r_dut_reset <= w_dut_reset_nxt;
            r_init_req  <= w_init_req_nxt;
            if (w_cyc_en && (r_cycles != '1)) r_cycles <= r_cycles + 64'd1;
`ifdef SIM_RUN_CTRL_STEP_LIMIT_EN
            r_steps     <= w_steps_nxt;
`endif
        end
    end

    assign dut_reset = r_dut_reset;
    assign init_req  = r_init_req;
    assign step_req  = r_step_req;
    assign perf_dump = r_perf_dump;
    assign finish    = r_finish;
    assign trap_code = r_trap_code;
    assign cycles    = r_cycles;
    assign pend_ovf  = r_pend_ovf;
`ifdef SIM_RUN_CTRL_STEP_LIMIT_EN
    assign steps     = r_steps;
`endif

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Self-checking bench for sim_run_ctrl: table of step scenarios driven through a
// scoreboarded host model, plus hand-written trap, reset and timeout sequences.
module tb_sim_run_ctrl;

    localparam int RESET_CYCLES = 50;
    localparam int DUMP_CYCLES  = 25;
    localparam int PEND_MAX     = 15;

    logic        clock = 1'b0;
    logic        reset;
    logic [63:0] cfg_max_cycles;
    logic        difftest_step;
    logic        step_rsp_valid;
    logic [7:0]  step_rsp_trap;
    logic        dut_reset, init_req, step_req, perf_dump, finish, pend_ovf;
    logic [7:0]  trap_code;
    logic [63:0] cycles;
`ifdef SIM_RUN_CTRL_STEP_LIMIT_EN
    logic [63:0] cfg_max_steps;
    logic [63:0] steps;
`endif

    sim_run_ctrl #(
        .RESET_CYCLES(RESET_CYCLES),
        .DUMP_CYCLES (DUMP_CYCLES),
        .PEND_W      (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .cfg_max_cycles(cfg_max_cycles),
`ifdef SIM_RUN_CTRL_STEP_LIMIT_EN
        .cfg_max_steps (cfg_max_steps),
        .steps         (steps),
`endif
        .difftest_step (difftest_step),
        .dut_reset     (dut_reset),
        .init_req      (init_req),
        .step_req      (step_req),
        .step_rsp_valid(step_rsp_valid),
        .step_rsp_trap (step_rsp_trap),
        .perf_dump     (perf_dump),
        .finish        (finish),
        .trap_code     (trap_code),
        .cycles        (cycles),
        .pend_ovf      (pend_ovf)
    );

    always #5 clock = ~clock;

    typedef struct {
        int   extra;
        int   delay;
        int   exp_hs;
        logic exp_ovf;
    } vec_t;

    vec_t vecs[4];

    int n_cmp = 0;
    int n_err = 0;

    int sb[$];
    int push_id = 0;
    int pop_id  = 0;

    logic       host_en    = 1'b0;
    int         host_delay = 3;
    logic [7:0] host_trap  = 8'h00;
    int         hs_cnt     = 0;
    int         hi_cnt     = 0;
    logic       prev_req   = 1'b0;
    logic       rsp_sent   = 1'b0;

    logic [63:0] exp_cyc = 64'd0;
    logic        cnt_en  = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Expected cycle count: one per clock spent in INIT/RUN/WAIT, i.e. after
    // dut_reset has fallen and before the dump window or finish.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (reset)       exp_cyc = 64'd0;
            else if (cnt_en) exp_cyc = exp_cyc + 64'd1;
            cnt_en = !reset && !dut_reset && !perf_dump && !finish;
        end
    end

    // Host: pops the scoreboard on every new request, answers after host_delay
    // cycles of step_req, and expects step_req to drop once the answer is taken.
    initial begin
        int got;
        forever begin
            @(posedge clock);
            #1;
            if (host_en) begin
                step_rsp_valid = 1'b0;
                step_rsp_trap  = 8'h00;
                if (rsp_sent) begin
                    chk("req_drop_after_rsp", {63'd0, step_req}, 64'd0);
                    rsp_sent = 1'b0;
                end
                if (step_req && !prev_req) begin
                    hi_cnt = 0;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL spurious_step_req: got step_req=1, want no request (none expected)");
                    end else begin
                        got = sb.pop_front();
                        chk("step_order", got, pop_id);
                        pop_id++;
                    end
                end
                if (step_req) begin
                    hi_cnt++;
                    if (hi_cnt == host_delay) begin
                        step_rsp_valid = 1'b1;
                        step_rsp_trap  = host_trap;
                        hi_cnt         = 0;
                        rsp_sent       = 1'b1;
                        hs_cnt++;
                    end
                end
            end
            prev_req = step_req;
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_dut_reset"}, {63'd0, dut_reset}, 64'd1);
        chk({tag, "_init_req"},  {63'd0, init_req},  64'd0);
        chk({tag, "_step_req"},  {63'd0, step_req},  64'd0);
        chk({tag, "_perf_dump"}, {63'd0, perf_dump}, 64'd0);
        chk({tag, "_finish"},    {63'd0, finish},    64'd0);
        chk({tag, "_pend_ovf"},  {63'd0, pend_ovf},  64'd0);
        chk({tag, "_trap_code"}, {56'd0, trap_code}, 64'd0);
        chk({tag, "_cycles"},    cycles,             64'd0);
    endtask

    task automatic release_and_boot(input string tag);
        int n;
        n = 0;
        reset = 1'b0;
        while (dut_reset && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_hold_len"}, n, RESET_CYCLES);
        chk({tag, "_init_hi"},  {63'd0, init_req}, 64'd1);
        chk({tag, "_cyc_init"}, cycles, 64'd0);
        tick();
        chk({tag, "_init_lo"},  {63'd0, init_req}, 64'd0);
        chk({tag, "_cyc_run"},  cycles, 64'd1);
    endtask

    initial begin
        int c;
        int n;
        logic any_req;
        logic [63:0] prev_cyc;

        vecs[0] = '{extra: 0,  delay: 3,  exp_hs: 1,  exp_ovf: 1'b0};
        vecs[1] = '{extra: 4,  delay: 6,  exp_hs: 5,  exp_ovf: 1'b0};
        vecs[2] = '{extra: 1,  delay: 1,  exp_hs: 2,  exp_ovf: 1'b0};
        vecs[3] = '{extra: 16, delay: 17, exp_hs: 16, exp_ovf: 1'b1};

        reset          = 1'b1;
        cfg_max_cycles = 64'd0;
        difftest_step  = 1'b0;
        step_rsp_valid = 1'b0;
        step_rsp_trap  = 8'h00;
`ifdef SIM_RUN_CTRL_STEP_LIMIT_EN
        cfg_max_steps  = 64'd0;
`endif
        repeat (3) tick();
        check_reset_vals("por");

        release_and_boot("boot1");
        host_en = 1'b1;

        for (int v = 0; v < 4; v++) begin
            int hs0;
            host_delay = vecs[v].delay;
            host_trap  = 8'h00;
            hs0        = hs_cnt;
            difftest_step = 1'b1;
            sb.push_back(push_id);
            push_id++;
            tick();
            difftest_step = 1'b0;
            chk($sformatf("v%0d_step_latency", v), {63'd0, step_req}, 64'd1);
            for (int i = 0; i < vecs[v].extra; i++) begin
                difftest_step = 1'b1;
                if (i < PEND_MAX) begin
                    sb.push_back(push_id);
                    push_id++;
                end
                tick();
            end
            difftest_step = 1'b0;
            c = 0;
            while (!(sb.size() == 0 && !step_req && (hs_cnt - hs0) == vecs[v].exp_hs) && c < 2000) begin
                tick();
                c++;
            end
            repeat (3) tick();
            chk($sformatf("v%0d_handshakes", v), hs_cnt - hs0, vecs[v].exp_hs);
            chk($sformatf("v%0d_sb_left", v), sb.size(), 0);
            chk($sformatf("v%0d_step_req_idle", v), {63'd0, step_req}, 64'd0);
            chk($sformatf("v%0d_pend_ovf", v), {63'd0, pend_ovf}, {63'd0, vecs[v].exp_ovf});
            chk($sformatf("v%0d_perf_dump", v), {63'd0, perf_dump}, 64'd0);
            chk($sformatf("v%0d_finish", v), {63'd0, finish}, 64'd0);
            chk($sformatf("v%0d_cycles", v), cycles, exp_cyc);
        end

        // Host trap ends the run through the dump window.
        host_delay = 2;
        host_trap  = 8'h01;
        difftest_step = 1'b1;
        sb.push_back(push_id);
        push_id++;
        tick();
        difftest_step = 1'b0;
        c = 0;
        while (!perf_dump && c < 100) begin
            tick();
            c++;
        end
        host_trap = 8'h00;
        chk("trap_dump_start", {63'd0, perf_dump}, 64'd1);
        chk("trap_code_latched", {56'd0, trap_code}, 64'h01);
        chk("trap_step_req", {63'd0, step_req}, 64'd0);
        n = 0;
        while (perf_dump && n < 100) begin
            n++;
            tick();
        end
        chk("trap_dump_len", n, DUMP_CYCLES);
        chk("trap_finish", {63'd0, finish}, 64'd1);
        difftest_step = 1'b1;
        any_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_req = any_req | step_req;
        end
        difftest_step = 1'b0;
        chk("done_ignores_step", {63'd0, any_req}, 64'd0);
        chk("done_finish_held", {63'd0, finish}, 64'd1);
        chk("done_trap_held", {56'd0, trap_code}, 64'h01);
        chk("done_cycles_frozen", cycles, exp_cyc);
        chk("done_sb_left", sb.size(), 0);

        // Asynchronous reset out of DONE, checked before the next clock edge.
        reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        repeat (2) tick();
        release_and_boot("boot2");

        // Cycle timeout with a host that never answers.
        host_en        = 1'b0;
        step_rsp_valid = 1'b0;
        step_rsp_trap  = 8'h00;
        cfg_max_cycles = 64'd100;
        difftest_step  = 1'b1;
        tick();
        difftest_step  = 1'b0;
        chk("to_step_latency", {63'd0, step_req}, 64'd1);
        prev_cyc = cycles;
        c = 0;
        while (!perf_dump && c < 300) begin
            prev_cyc = cycles;
            tick();
            c++;
        end
        chk("to_dump_start", {63'd0, perf_dump}, 64'd1);
        chk("to_fire_cycle", prev_cyc, 64'd100);
        chk("to_trap_code", {56'd0, trap_code}, 64'hFE);
        chk("to_step_req", {63'd0, step_req}, 64'd0);
        chk("to_cycles", cycles, exp_cyc);
        step_rsp_valid = 1'b1;
        step_rsp_trap  = 8'h05;
        n = 1;
        tick();
        step_rsp_valid = 1'b0;
        step_rsp_trap  = 8'h00;
        while (perf_dump && n < 100) begin
            n++;
            tick();
        end
        chk("to_dump_len", n, DUMP_CYCLES);
        chk("to_finish", {63'd0, finish}, 64'd1);
        chk("to_late_rsp_ignored", {56'd0, trap_code}, 64'hFE);
        chk("to_step_req_done", {63'd0, step_req}, 64'd0);

        reset = 1'b1;
        #1;
        check_reset_vals("done_rst");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sim_run_ctrl.md
Name: sim_run_ctrl

Overview:
- Synthesizable run sequencer between the simulation top and SimTop.
- Sequences DUT reset release and the one-shot host init request.
- Forwards each `difftest_step` to the host as a step request/response handshake and queues steps that arrive while a request is outstanding.
- On trap or cycle timeout: drives a perf-dump window, then raises a sticky finish request.

Parameters:
- RESET_CYCLES, 50, cycles `dut_reset` stays high after `reset` deasserts (≥1).
- DUMP_CYCLES, 25, cycles `perf_dump` is held after a trap (≥1).
- PEND_W, 4, width of the pending-step counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cfg_max_cycles  in  64  cycle limit; 0 = unlimited; sampled every cycle.
- difftest_step  in  1  one step per high cycle, from SimTop.
- dut_reset  out  1  reset to SimTop.
- init_req  out  1  one-cycle host-init pulse.
- step_req  out  1  step request to host; held until response.
- step_rsp_valid  in  1  host response strobe.
- step_rsp_trap  in  8  host trap code; 0 = continue.
- perf_dump  out  1  perf dump window.
- finish  out  1  sticky end-of-sim request.
- trap_code  out  8  final trap code.
- cycles  out  64  cycles counted since `dut_reset` fell.
- pend_ovf  out  1  sticky pending-counter overflow flag.

Behaviour:
- Reset values: `dut_reset`=1; `init_req`, `step_req`, `perf_dump`, `finish`, `pend_ovf`=0; `trap_code`=0; `cycles`=0; pending=0; state=HOLD; hold counter=0.
- Reset asserted mid-operation returns everything to these values immediately, whatever the state.
- **HOLD:** counts clocks after `reset` deasserts. At count RESET_CYCLES-1: `dut_reset`←0 and go to INIT.
- **INIT:** `init_req`=1 for exactly this one cycle, then RUN. `difftest_step` seen in INIT increments pending.
- `cycles` increments every clock in INIT/RUN/WAIT and freezes in DUMP/DONE. It saturates at all-ones.
- **RUN:**
  - If `difftest_step`=1 or pending≠0: `step_req`←1 next cycle and go to WAIT.
  - If pending≠0 and `difftest_step`=1 in the same cycle, pending is unchanged (one consumed, one added).
  - If pending≠0 and no step: pending decrements.
- **WAIT:** `step_req` held high. Each `difftest_step`=1 increments pending.
  - At max (2^PEND_W−1), the counter holds and `pend_ovf` is set.
  - On `step_rsp_valid`: `step_req`←0.
    - If `step_rsp_trap`≠0: latch `trap_code` and go to DUMP.
    - Else return to RUN.
  - `step_rsp_valid` outside WAIT is ignored.
- **Timeout:** when `cfg_max_cycles`≠0 and `cycles`==`cfg_max_cycles` in RUN or WAIT, timeout wins over a same-cycle response.
  - `trap_code`←8'hFE, `step_req`←0, go to DUMP.
  - Any outstanding step is abandoned; a later response is ignored.
- **DUMP:** `perf_dump`=1 for exactly DUMP_CYCLES cycles, then `perf_dump`←0, `finish`←1, and go to DONE.
- **DONE:** terminal until reset. `finish` and `trap_code` are held. `difftest_step` is ignored.
- Latency from `difftest_step` in RUN (pending=0) to `step_req`=1 is 1 cycle. The response is consumed in the cycle `step_rsp_valid` is high.

Optional Feature:
- Macro: SIM_RUN_CTRL_STEP_LIMIT_EN.
- With the macro defined, the block adds:
  - input `cfg_max_steps` (64); 0 = unlimited.
  - output `steps` (64), counting accepted non-trap responses.
- When `steps` reaches a nonzero `cfg_max_steps`, the block enters DUMP with `trap_code`=8'h09 (checkpoint max reached).
- A same-cycle host trap takes precedence over the step limit.
- Without the macro, neither port exists and no step limit applies.

Test Plan:
- Reset release: deassert `reset`, RESET_CYCLES=50 → `dut_reset` falls after 50 clocks, `init_req` high exactly 1 cycle, `cycles`=0 then counting.
- Single step: `difftest_step` pulse, host answers trap=0 after 3 cycles → `step_req` high 3 cycles, returns to RUN, no `perf_dump`.
- Back-to-back steps: 4 `difftest_step` pulses while a step is outstanding → pending=4, then 4 more `step_req` handshakes, pending=0, `pend_ovf`=0.
- Overflow: 16 pulses in WAIT with PEND_W=4 → pending=15, `pend_ovf`=1.
- Trap: response trap=1 → `trap_code`=1, `perf_dump` high 25 cycles, `finish`=1 next cycle and stays high; further steps ignored.
- Timeout: `cfg_max_cycles`=100 with no host response → `trap_code`=8'hFE when `cycles`==100, then DUMP→DONE; a late `step_rsp_valid` has no effect; asserting `reset` in DONE restores all reset values.
